// File: rtl/cv32e41p_apu_resp_buffer.sv
// Credit-limited response buffer between the core APU port and the FPU wrapper.
// Bounds outstanding FPU operations and queues results until the core accepts them.
module cv32e41p_apu_resp_buffer #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FLAGS_WIDTH = 5,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   core_req_i,
    output logic                   core_gnt_o,
    output logic                   fpu_req_o,
    input  logic                   fpu_gnt_i,

    input  logic                   fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]  fpu_rdata_i,
    input  logic [FLAGS_WIDTH-1:0] fpu_rflags_i,

    output logic                   core_rvalid_o,
    input  logic                   core_rready_i,
    output logic [DATA_WIDTH-1:0]  core_rdata_o,
    output logic [FLAGS_WIDTH-1:0] core_rflags_o,

    output logic [CW-1:0]          outstanding_o,
    output logic                   err_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = DATA_WIDTH + FLAGS_WIDTH;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] occ_reg, occ_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [EW-1:0] head_reg, head_next;
    logic          rvalid_reg, rvalid_next;
    logic          err_reg, err_next;

    logic          credit_ok;
    logic          accept;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          overflow;
    logic          spurious;
    logic          dec;
    logic [CW:0]   committed;
    logic [EW-1:0] wdata;

    // Request side depends only on registered state, never on core_rready_i.
    assign credit_ok  = (outstanding_reg < CW'(DEPTH));
    assign fpu_req_o  = core_req_i & credit_ok;
    assign core_gnt_o = core_req_i & credit_ok & fpu_gnt_i;
    assign accept     = core_req_i & core_gnt_o;

    assign pop      = rvalid_reg & core_rready_i;
    assign full     = (occ_reg == CW'(DEPTH));
    assign push_ok  = fpu_rvalid_i & (~full | pop);
    assign overflow = fpu_rvalid_i & full & ~pop;
    assign wdata    = {fpu_rflags_i, fpu_rdata_i};

    // An accept in the same cycle counts as in flight, so zero-latency results are legal.
    assign committed = {1'b0, outstanding_reg} + {{CW{1'b0}}, accept};
    assign spurious  = fpu_rvalid_i & (committed <= {1'b0, occ_reg});

    // Never wrap below zero, even after a spurious result has already flagged an error.
    assign dec = pop & (outstanding_reg != '0);

    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        occ_next         = occ_reg;
        outstanding_next = outstanding_reg;
        head_next        = head_reg;
        rvalid_next      = rvalid_reg;
        err_next         = err_reg | overflow | spurious;

        if (push_ok) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end

        case ({push_ok, pop})
            2'b10:   occ_next = occ_reg + CW'(1);
            2'b01:   occ_next = occ_reg - CW'(1);
            default: occ_next = occ_reg;
        endcase

        case ({accept, dec})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        // The new head is the entry being written only when the FIFO is empty after the pop.
        rvalid_next = (occ_next != '0);
        if (occ_next != '0) begin
            if (push_ok && (rd_ptr_next == wr_ptr_reg)) begin
                head_next = wdata;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            outstanding_reg <= '0;
            head_reg        <= '0;
            rvalid_reg      <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            occ_reg         <= occ_next;
            outstanding_reg <= outstanding_next;
            head_reg        <= head_next;
            rvalid_reg      <= rvalid_next;
            err_reg         <= err_next;
        end
    end

    assign core_rvalid_o = rvalid_reg;
    assign core_rdata_o  = head_reg[DATA_WIDTH-1:0];
    assign core_rflags_o = head_reg[EW-1:DATA_WIDTH];
    assign outstanding_o = outstanding_reg;
    assign err_o         = err_reg;

`ifndef SYNTHESIS
    a_pop_has_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rvalid_reg && !err_reg) |-> (outstanding_reg != '0));

    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_reg <= CW'(DEPTH));

    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        occ_reg <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_cv32e41p_apu_resp_buffer.sv
// Randomized and directed bench for cv32e41p_apu_resp_buffer against a queue-based model.
module tb_cv32e41p_apu_resp_buffer;

    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int FW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          core_req_i;
    logic          core_gnt_o;
    logic          fpu_req_o;
    logic          fpu_gnt_i;
    logic          fpu_rvalid_i;
    logic [DW-1:0] fpu_rdata_i;
    logic [FW-1:0] fpu_rflags_i;
    logic          core_rvalid_o;
    logic          core_rready_i;
    logic [DW-1:0] core_rdata_o;
    logic [FW-1:0] core_rflags_o;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    cv32e41p_apu_resp_buffer #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .FLAGS_WIDTH(FW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_gnt_o   (core_gnt_o),
        .fpu_req_o    (fpu_req_o),
        .fpu_gnt_i    (fpu_gnt_i),
        .fpu_rvalid_i (fpu_rvalid_i),
        .fpu_rdata_i  (fpu_rdata_i),
        .fpu_rflags_i (fpu_rflags_i),
        .core_rvalid_o(core_rvalid_o),
        .core_rready_i(core_rready_i),
        .core_rdata_o (core_rdata_o),
        .core_rflags_o(core_rflags_o),
        .outstanding_o(outstanding_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: result queue, in-flight+buffered op count, sticky error.
    logic [FW+DW-1:0] q[$];
    int               m_out = 0;
    bit               m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model.
    task automatic cyc(input logic req, input logic gnt, input logic rv,
                       input logic [DW-1:0] d, input logic [FW-1:0] f, input logic rr);
        bit exp_req, acc, pop, was_full;
        logic [FW+DW-1:0] head;
        core_req_i    = req;
        fpu_gnt_i     = gnt;
        fpu_rvalid_i  = rv;
        fpu_rdata_i   = d;
        fpu_rflags_i  = f;
        core_rready_i = rr;
        #1;
        exp_req = req && (m_out < DEPTH);
        check("fpu_req", fpu_req_o, exp_req);
        check("core_gnt", core_gnt_o, exp_req && gnt);
        check("rvalid", core_rvalid_o, q.size() != 0);
        if (q.size() != 0) begin
            head = q[0];
            check("rdata", core_rdata_o, head[DW-1:0]);
            check("rflags", core_rflags_o, head[FW+DW-1:DW]);
        end
        check("outstanding", outstanding_o, m_out);
        check("err", err_o, m_err);

        acc      = exp_req && gnt;
        pop      = (q.size() != 0) && rr;
        was_full = (q.size() == DEPTH);
        if (rv && (m_out + int'(acc) == q.size())) m_err = 1'b1;
        if (pop) begin
            head = q.pop_front();
            $display("pop data=%08h flags=%02h t=%0t", head[DW-1:0], head[FW+DW-1:DW], $time);
        end
        if (rv) begin
            if (!was_full || pop) q.push_back({f, d});
            else m_err = 1'b1;
        end
        m_out = m_out + int'(acc);
        if (pop && m_out > 0) m_out = m_out - 1;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Assert reset between clock edges and check that it takes effect without a clock.
    task automatic do_reset();
        core_req_i    = 1'b0;
        fpu_gnt_i     = 1'b0;
        fpu_rvalid_i  = 1'b0;
        core_rready_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_rvalid", core_rvalid_o, 1'b0);
        check("rst_rdata", core_rdata_o, '0);
        check("rst_rflags", core_rflags_o, '0);
        check("rst_outstanding", outstanding_o, '0);
        check("rst_err", err_o, 1'b0);
        check("rst_fpu_req", fpu_req_o, 1'b0);
        q.delete();
        m_out = 0;
        m_err = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni        = 1'b0;
        core_req_i    = 1'b0;
        fpu_gnt_i     = 1'b0;
        fpu_rvalid_i  = 1'b0;
        fpu_rdata_i   = '0;
        fpu_rflags_i  = '0;
        core_rready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        do_reset();

        // Single op: accept, result two cycles later, popped on arrival.
        cyc(1, 1, 0, 32'h0, 5'h0, 1);
        cyc(0, 0, 0, 32'h0, 5'h0, 1);
        cyc(0, 0, 1, 32'h3F800000, 5'h0, 1);
        cyc(0, 0, 0, 32'h0, 5'h0, 1);
        cyc(0, 0, 0, 32'h0, 5'h0, 1);

        // Randomized legal traffic, including zero-latency responses.
        for (int i = 0; i < 400; i++) begin
            logic req, gnt, rr, rv;
            int   inflight;
            req      = 1'($urandom_range(0, 1));
            gnt      = ($urandom_range(0, 9) < 7);
            rr       = ($urandom_range(0, 9) < 6);
            inflight = m_out - q.size() + ((req && gnt && m_out < DEPTH) ? 1 : 0);
            rv       = (inflight > 0) && ($urandom_range(0, 9) < 4);
            cyc(req, gnt, rv, $urandom, 5'($urandom_range(0, 31)), rr);
        end
        do_reset();

        // Credit stall and ordering under backpressure, then push+pop while full.
        cyc(1, 1, 0, 32'h0, 5'h0, 0);
        cyc(1, 1, 0, 32'h0, 5'h0, 0);
        cyc(1, 1, 1, 32'hA, 5'h1, 0);
        cyc(1, 1, 1, 32'hB, 5'h2, 0);
        cyc(1, 1, 0, 32'h0, 5'h0, 0);
        cyc(1, 1, 1, 32'hC, 5'h3, 1);
        cyc(1, 1, 0, 32'h0, 5'h0, 0);
        cyc(0, 0, 0, 32'h0, 5'h0, 1);
        cyc(0, 0, 0, 32'h0, 5'h0, 1);
        cyc(0, 0, 0, 32'h0, 5'h0, 0);
        do_reset();

        // Spurious responses with nothing in flight, then overflow drop, then reset with 2 outstanding.
        cyc(0, 0, 1, 32'h11111111, 5'h4, 0);
        cyc(0, 0, 0, 32'h0, 5'h0, 0);
        cyc(0, 0, 1, 32'h22222222, 5'h5, 0);
        cyc(0, 0, 1, 32'h33333333, 5'h6, 0);
        cyc(0, 0, 0, 32'h0, 5'h0, 0);
        cyc(1, 1, 0, 32'h0, 5'h0, 0);
        cyc(1, 1, 0, 32'h0, 5'h0, 0);
        cyc(0, 0, 0, 32'h0, 5'h0, 0);
        do_reset();
        cyc(0, 0, 0, 32'h0, 5'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
